// File: rtl/serial_pattern_gen.sv
// Serializes 2-bit symbol codes into 5-bit frames (MSB first) followed by a zero guard gap.
// Optional SPG_FRAME_CNT_EN adds a saturating count of completed frames on frame_cnt.
module serial_pattern_gen #(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] in_code,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       x,
   output logic       busy,
   output logic       done,
   output logic       err,
`ifdef SPG_FRAME_CNT_EN
   output logic [7:0] frame_cnt,
`endif
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StSend = 2'b01,
      StGap  = 2'b10
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic [4:0] shreg_q, shreg_d;
   logic [4:0] pattern;
   logic       x_q, x_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   // Codes 01 and 11 are the only valid symbols; bit 1 selects the middle 1.
   assign pattern = in_code[1] ? 5'b10101 : 5'b10001;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      shreg_d   = shreg_q;
      x_d       = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (in_code[0]) begin
                  x_d       = pattern[4];
                  shreg_d   = {pattern[3:0], 1'b0};
                  bit_cnt_d = 3'd1;
                  state_d   = StSend;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StSend: begin
            if (bit_cnt_q == 3'd5) begin
               bit_cnt_d = 3'd0;
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d   = StGap;
                  gap_cnt_d = 4'd1;
               end
            end else begin
               x_d       = shreg_q[4];
               shreg_d   = {shreg_q[3:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == 4'(GAP_CYCLES)) begin
               state_d   = StIdle;
               gap_cnt_d = 4'd0;
               done_d    = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= 3'd0;
         gap_cnt_q <= 4'd0;
         shreg_q   <= 5'd0;
         x_q       <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         shreg_q   <= shreg_d;
         x_q       <= x_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef SPG_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 8'd0;
      end else if (done_d && (frame_cnt_q != 8'hff)) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign in_ready = (state_q == StIdle);
   assign busy     = (state_q != StIdle);
   assign state    = state_q;
   assign x        = x_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench: two instances (gap 4 and gap 0) driven by shared stimulus and compared
// cycle by cycle against a queue-based model of the transmitted line.
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_code = 2'b00;
   logic       in_valid = 1'b0;

   logic       rdy4, x4, busy4, done4, err4;
   logic [1:0] st4;
   logic       rdy0, x0, busy0, done0, err0;
   logic [1:0] st0;
`ifdef SPG_FRAME_CNT_EN
   logic [7:0] fc4, fc0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_pattern_gen #(.GAP_CYCLES(4)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .in_code  (in_code),
      .in_valid (in_valid),
      .in_ready (rdy4),
      .x        (x4),
      .busy     (busy4),
      .done     (done4),
      .err      (err4),
`ifdef SPG_FRAME_CNT_EN
      .frame_cnt(fc4),
`endif
      .state    (st4)
   );

   serial_pattern_gen #(.GAP_CYCLES(0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_code  (in_code),
      .in_valid (in_valid),
      .in_ready (rdy0),
      .x        (x0),
      .busy     (busy0),
      .done     (done0),
      .err      (err0),
`ifdef SPG_FRAME_CNT_EN
      .frame_cnt(fc0),
`endif
      .state    (st0)
   );

   // Observed outputs packed as {x, done, err, busy, in_ready, state}
   logic [6:0] obs [2];
   always_comb begin
      obs[0] = {x4, done4, err4, busy4, rdy4, st4};
      obs[1] = {x0, done0, err0, busy0, rdy0, st0};
   end

   // Model: a busy instance owes the queued line bits, then one done cycle.
   bit mq [2][$];
   bit mbusy [2];
   bit e_x [2];
   bit e_done [2];
   bit e_err [2];
   int fcnt [2];

   function automatic int gap_of(input int i);
      return (i == 0) ? 4 : 0;
   endfunction

   task automatic model_step();
      bit [4:0] pat;
      for (int i = 0; i < 2; i++) begin
         e_done[i] = 1'b0;
         e_err[i]  = 1'b0;
         e_x[i]    = 1'b0;
         if (rst) begin
            mq[i].delete();
            mbusy[i] = 1'b0;
            fcnt[i]  = 0;
         end else if (mbusy[i]) begin
            if (mq[i].size() > 0) begin
               e_x[i] = mq[i].pop_front();
            end else begin
               e_done[i] = 1'b1;
               mbusy[i]  = 1'b0;
               if (fcnt[i] < 255) fcnt[i]++;
            end
         end else if (in_valid) begin
            if (in_code == 2'b01 || in_code == 2'b11) begin
               pat = (in_code == 2'b11) ? 5'b10101 : 5'b10001;
               for (int b = 4; b >= 0; b--) mq[i].push_back(pat[b]);
               for (int g = 0; g < gap_of(i); g++) mq[i].push_back(1'b0);
               e_x[i]   = mq[i].pop_front();
               mbusy[i] = 1'b1;
            end else begin
               e_err[i] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [6:0] exp_vec(input int i);
      logic [1:0] st;
      if (!mbusy[i]) st = 2'b00;
      else if (mq[i].size() >= gap_of(i)) st = 2'b01;
      else st = 2'b10;
      return {e_x[i], e_done[i], e_err[i], mbusy[i], ~mbusy[i], st};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) rst = 1'b0;
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 7'b0000100) begin
               errors++;
               $display("FAIL reset dut%0d cycle %0d: got %b expected %b", i, c, obs[i], 7'b0000100);
            end
         end
      end
   endtask

   task automatic test_single_01();
      logic [8:0] xs = '0;
      int nd = 0, nb = 0;
      in_code = 2'b01;
      in_valid = 1'b1;
      for (int c = 0; c < 13; c++) begin
         tick();
         in_valid = 1'b0;
         if (c < 9) xs = {xs[7:0], x4};
         nb += busy4;
         nd += done4;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL single_01 dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
      end
      checks++;
      if (xs !== 9'b100010000) begin
         errors++;
         $display("FAIL single_01 line: got %b expected %b", xs, 9'b100010000);
      end
      checks++;
      if (nb != 9 || nd != 1) begin
         errors++;
         $display("FAIL single_01 busy/done counts: got %0d/%0d expected 9/1", nb, nd);
      end
   endtask

   task automatic test_code_11();
      logic [4:0] w = '0;
      int hits = 0;
      in_code = 2'b11;
      in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         in_valid = 1'b0;
         w = {w[3:0], x4};
         if (w == 5'b10101) hits++;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL code_11 dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
      end
      checks++;
      if (hits != 1) begin
         errors++;
         $display("FAIL code_11 frame hits: got %0d expected 1", hits);
      end
   endtask

   task automatic test_invalid();
      int ne = 0, nbd = 0;
      in_code = 2'b10;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         in_valid = 1'b0;
         ne += err4;
         nbd += busy4 + done4 + x4;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL invalid dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
      end
      checks++;
      if (ne != 1 || nbd != 0) begin
         errors++;
         $display("FAIL invalid err/activity: got %0d/%0d expected 1/0", ne, nbd);
      end
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_code = 2'b01;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         in_valid = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (x4 !== 1'b0 || st4 !== 2'b00 || x0 !== 1'b0 || st0 !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid truncate: got x=%b%b st=%b/%b expected x=00 st=00/00",
                  x4, x0, st4, st0);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         nd += done4 + done0;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL reset_mid dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
      end
      checks++;
      if (nd != 0) begin
         errors++;
         $display("FAIL reset_mid done count: got %0d expected 0", nd);
      end
`ifdef SPG_FRAME_CNT_EN
      checks++;
      if (fc4 !== 8'd0 || fc0 !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid frame_cnt: got %0d/%0d expected 0/0", fc4, fc0);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [16:0] xs = '0;
      int nd = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_code = 2'b01;
      in_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (c == 12) in_valid = 1'b0;
         if (c < 17) xs = {xs[15:0], x0};
         nd += done0;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL back_to_back dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
      end
      checks++;
      if (xs !== 17'b10001010001010001) begin
         errors++;
         $display("FAIL back_to_back line: got %b expected %b", xs, 17'b10001010001010001);
      end
      checks++;
      if (nd != 3) begin
         errors++;
         $display("FAIL back_to_back done count: got %0d expected 3", nd);
      end
`ifdef SPG_FRAME_CNT_EN
      checks++;
      if (fc0 !== 8'd3) begin
         errors++;
         $display("FAIL back_to_back frame_cnt: got %0d expected 3", fc0);
      end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst      = ($urandom_range(39) == 0);
         in_valid = ($urandom_range(2) != 0);
         in_code  = 2'($urandom_range(3));
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== exp_vec(i)) begin
               errors++;
               $display("FAIL random dut%0d cycle %0d: got %b expected %b", i, c, obs[i], exp_vec(i));
            end
         end
`ifdef SPG_FRAME_CNT_EN
         checks++;
         if (fc4 !== 8'(fcnt[0]) || fc0 !== 8'(fcnt[1])) begin
            errors++;
            $display("FAIL random frame_cnt cycle %0d: got %0d/%0d expected %0d/%0d",
                     c, fc4, fc0, fcnt[0], fcnt[1]);
         end
`endif
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_01();
      test_code_11();
      test_invalid();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
